// File: rtl/jcc_sequencer.sv
// rtl/jcc_sequencer.sv - 8086 conditional branch / LOOP / JCXZ sequencer
module jcc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] flags,
  input  logic [15:0] cx_in,
  input  logic [15:0] ip_in,
  input  logic [7:0]  disp,
  input  logic        disp_valid,
  output logic        disp_ready,
  output logic [15:0] cx_out,
  output logic        cx_wr,
  output logic [15:0] ip_out,
  output logic        ip_wr,
  output logic        taken,
  output logic        busy,
  output logic        done
);

  // Architectural FLAGS bit positions
  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int OF_IDX = 11;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, COMMIT} state_t;

  state_t      state;
  logic [7:0]  op_l;
  logic [15:0] cx_l;
  logic [15:0] ip_l;
  logic [7:0]  disp_l;
  logic        cf_l, pf_l, zf_l, sf_l, of_l;

  logic [15:0] cx_dec;
  logic [15:0] target;
  logic        jcc_cond;
  logic        decision;
  logic        is_loop_l;

  // Only five FLAGS bits feed branch conditions; the rest are intentionally ignored
  logic unused_flags;
  assign unused_flags = ^{flags[15:12], flags[10:8], flags[5:3], flags[1]};

  function automatic logic is_supported(input logic [7:0] op);
    return (op[7:4] == 4'h7) || (op[7:2] == 6'b111000);
  endfunction

  assign disp_ready = (state == FETCH);
  assign busy       = (state != IDLE);
  assign is_loop_l  = (op_l[7:2] == 6'b111000) && (op_l[1:0] != 2'b11);
  assign cx_dec     = cx_l - 16'd1;
  assign target     = ip_l + {{8{disp_l[7]}}, disp_l};

  // Branch condition from latched opcode, flags and CX; odd Jcc opcodes negate the even one
  always_comb begin
    jcc_cond = 1'b0;
    case (op_l[3:1])
      3'd0: jcc_cond = of_l;
      3'd1: jcc_cond = cf_l;
      3'd2: jcc_cond = zf_l;
      3'd3: jcc_cond = cf_l | zf_l;
      3'd4: jcc_cond = sf_l;
      3'd5: jcc_cond = pf_l;
      3'd6: jcc_cond = sf_l ^ of_l;
      3'd7: jcc_cond = (sf_l ^ of_l) | zf_l;
      default: jcc_cond = 1'b0;
    endcase
    decision = 1'b0;
    case (op_l)
      8'hE0:   decision = (cx_dec != 16'd0) & ~zf_l;
      8'hE1:   decision = (cx_dec != 16'd0) & zf_l;
      8'hE2:   decision = (cx_dec != 16'd0);
      8'hE3:   decision = (cx_l == 16'd0);
      default: decision = jcc_cond ^ op_l[0];
    endcase
  end

  // Sequencer FSM; strobes are registered and default low so each lasts exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_l   <= '0;
      cx_l   <= '0;
      ip_l   <= '0;
      disp_l <= '0;
      cf_l   <= 1'b0;
      pf_l   <= 1'b0;
      zf_l   <= 1'b0;
      sf_l   <= 1'b0;
      of_l   <= 1'b0;
      cx_out <= '0;
      cx_wr  <= 1'b0;
      ip_out <= '0;
      ip_wr  <= 1'b0;
      taken  <= 1'b0;
      done   <= 1'b0;
    end else begin
      cx_out <= '0;
      cx_wr  <= 1'b0;
      ip_out <= '0;
      ip_wr  <= 1'b0;
      taken  <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_l <= opcode;
            cx_l <= cx_in;
            ip_l <= ip_in;
            cf_l <= flags[CF_IDX];
            pf_l <= flags[PF_IDX];
            zf_l <= flags[ZF_IDX];
            sf_l <= flags[SF_IDX];
            of_l <= flags[OF_IDX];
            if (is_supported(opcode)) begin
              state <= FETCH;
            end else begin
              state <= COMMIT;
              done  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (disp_valid) begin
            disp_l <= disp;
            state  <= EVAL;
            if (is_loop_l) begin
              cx_wr  <= 1'b1;
              cx_out <= cx_dec;
            end
          end
        end
        EVAL: begin
          state <= COMMIT;
          done  <= 1'b1;
          taken <= decision;
          ip_wr <= decision;
          ip_out <= decision ? target : 16'd0;
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jcc_sequencer.sv
// tb/tb_jcc_sequencer.sv - scoreboard testbench for jcc_sequencer
module tb_jcc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] flags;
  logic [15:0] cx_in;
  logic [15:0] ip_in;
  logic [7:0]  disp;
  logic        disp_valid;
  logic        disp_ready;
  logic [15:0] cx_out;
  logic        cx_wr;
  logic [15:0] ip_out;
  logic        ip_wr;
  logic        taken;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sup;
    logic        tk;
    logic [15:0] ip;
    logic        cxw;
    logic [15:0] cx;
    int          lat;
  } exp_t;

  exp_t sb[$];

  jcc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .flags(flags),
    .cx_in(cx_in), .ip_in(ip_in), .disp(disp), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .cx_out(cx_out), .cx_wr(cx_wr), .ip_out(ip_out),
    .ip_wr(ip_wr), .taken(taken), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [15:0] fl,
                                 input logic [15:0] cx, input logic [15:0] ip,
                                 input logic [7:0] d, input int stall);
    exp_t e;
    logic of, cf, zf, sf, pf;
    logic [15:0] cxm;
    of = fl[11]; cf = fl[0]; zf = fl[6]; sf = fl[7]; pf = fl[2];
    cxm = cx - 16'd1;
    e.sup = 1'b1; e.tk = 1'b0; e.cxw = 1'b0;
    case (op)
      8'h70: e.tk = of;
      8'h71: e.tk = !of;
      8'h72: e.tk = cf;
      8'h73: e.tk = !cf;
      8'h74: e.tk = zf;
      8'h75: e.tk = !zf;
      8'h76: e.tk = cf || zf;
      8'h77: e.tk = !cf && !zf;
      8'h78: e.tk = sf;
      8'h79: e.tk = !sf;
      8'h7A: e.tk = pf;
      8'h7B: e.tk = !pf;
      8'h7C: e.tk = (sf != of);
      8'h7D: e.tk = (sf == of);
      8'h7E: e.tk = zf || (sf != of);
      8'h7F: e.tk = !zf && (sf == of);
      8'hE0: begin e.cxw = 1'b1; e.tk = (cxm != 0) && !zf; end
      8'hE1: begin e.cxw = 1'b1; e.tk = (cxm != 0) && zf; end
      8'hE2: begin e.cxw = 1'b1; e.tk = (cxm != 0); end
      8'hE3: e.tk = (cx == 16'd0);
      default: e.sup = 1'b0;
    endcase
    e.lat = e.sup ? 3 + stall : 1;
    e.ip  = e.tk ? ip + {{8{d[7]}}, d} : 16'd0;
    e.cx  = e.cxw ? cxm : 16'd0;
    return e;
  endfunction

  task automatic run_op(input logic [7:0] op, input logic [15:0] fl, input logic [15:0] cx,
                        input logic [15:0] ip, input logic [7:0] d, input int stall, input bit poke);
    exp_t e;
    int cxw_n, cxw_cyc, dr_n;
    logic [15:0] cxv;
    bit fin;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    sb.push_back(model(op, fl, cx, ip, d, stall));
    start = 1'b1; opcode = op; flags = fl; cx_in = cx; ip_in = ip; disp = d; disp_valid = 1'b0;
    cxw_n = 0; cxw_cyc = 0; dr_n = 0; cxv = 16'd0; fin = 1'b0;
    for (int n = 1; n <= 40 && !fin; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_c1", busy, 1);
      if (disp_ready) dr_n++;
      if (cx_wr) begin cxw_n++; cxv = cx_out; cxw_cyc = n; end
      if (!cx_wr && cx_out != 16'd0) check("cx_out_zero", cx_out, 0);
      if (!ip_wr && ip_out != 16'd0) check("ip_out_zero", ip_out, 0);
      if (done) begin
        fin = 1'b1;
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("taken", taken, e.tk);
        check("ip_wr", ip_wr, e.tk);
        check("ip_out", ip_out, e.ip);
        check("busy_done", busy, 1);
        check("cx_wr_count", cxw_n, e.cxw ? 1 : 0);
        check("cx_out", cxv, e.cx);
        if (e.cxw) check("cx_wr_cycle", cxw_cyc, e.lat - 1);
        check("disp_ready_cycles", dr_n, e.sup ? stall + 1 : 0);
      end
      start  = poke && (n == 1);
      opcode = 8'($urandom);
      flags  = 16'($urandom);
      cx_in  = 16'($urandom);
      ip_in  = 16'($urandom);
      disp_valid = (n > stall);
      disp   = disp_valid ? d : 8'($urandom);
    end
    if (!fin) begin
      check("timeout", 0, 1);
      void'(sb.pop_front());
    end
    start = 1'b0;
    disp_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {disp_ready, cx_wr, ip_wr, taken, busy, done, cx_out, ip_out}, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; opcode = '0; flags = '0; cx_in = '0; ip_in = '0;
    disp = '0; disp_valid = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    run_op(8'h74, 16'h0040, 16'h1234, 16'h0100, 8'hFE, 0, 1'b0);   // JE taken
    run_op(8'h7F, 16'h0080, 16'h1234, 16'h0200, 8'h10, 0, 1'b0);   // JNLE not taken
    run_op(8'hE2, 16'h0000, 16'h0001, 16'h0300, 8'h20, 0, 1'b0);   // LOOP to zero
    run_op(8'hE2, 16'h0000, 16'h0000, 16'h0300, 8'h20, 0, 1'b0);   // LOOP wrap
    run_op(8'hE0, 16'h0040, 16'h0005, 16'h0400, 8'h05, 0, 1'b0);   // LOOPNE, ZF=1
    run_op(8'hE3, 16'h0000, 16'h0000, 16'h0500, 8'h7F, 0, 1'b0);   // JCXZ
    run_op(8'h72, 16'h0001, 16'h0000, 16'hFFFF, 8'h02, 4, 1'b1);   // JB, stall, start during busy
    run_op(8'h90, 16'hFFFF, 16'h0001, 16'h0600, 8'h11, 0, 1'b0);   // unsupported
    run_op(8'h74, 16'h0040, 16'h0000, 16'h0700, 8'h01, 0, 1'b0);   // back-to-back after unsupported
    run_op(8'hE1, 16'h0040, 16'h0003, 16'h0050, 8'h80, 1, 1'b0);   // LOOPE backward
    for (int i = 0; i < 16; i++)
      run_op(8'h70 + 8'(i), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), 1'b0);

    // Abort in FETCH with reset
    @(negedge clk);
    start = 1'b1; opcode = 8'hE2; cx_in = 16'h0009; ip_in = 16'h1000; disp = 8'h04;
    @(negedge clk);
    start = 1'b0;
    check("abort_fetch", disp_ready, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("abort_outputs");
    disp_valid = 1'b1;
    @(negedge clk);
    check_all_zero("abort_hold");
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done || busy || disp_ready || cx_wr || ip_wr) bad++;
    end
    check("post_reset_idle", bad, 0);
    disp_valid = 1'b0;
    run_op(8'h75, 16'h0000, 16'h0000, 16'h2000, 8'h08, 0, 1'b0);   // recovers after reset

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jcc_sequencer.md
JCC_SEQUENCER -- requirements
Module: jcc_sequencer

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 start  input  1  one-cycle pulse; opcode, flags, cx_in and ip_in are valid this cycle.
REQ-004 opcode  input  8  branch opcode.
REQ-005 flags  input  16  architectural FLAGS; uses the codebase OF_IDX, CF_IDX, ZF_IDX, SF_IDX and PF_IDX bit positions.
REQ-006 cx_in  input  16  current CX.
REQ-007 ip_in  input  16  IP of the byte following the displacement.
REQ-008 disp  input  8  rel8 displacement byte from prefetch.
REQ-009 disp_valid  input  1  disp is valid.
REQ-010 disp_ready  output  1  sequencer accepts disp this cycle.
REQ-011 cx_out  output  16  decremented CX.
REQ-012 cx_wr  output  1  one-cycle CX write strobe.
REQ-013 ip_out  output  16  branch target.
REQ-014 ip_wr  output  1  one-cycle IP write strobe.
REQ-015 taken  output  1  branch decision; valid while done=1.
REQ-016 busy  output  1  high from the cycle after an accepted start until done, inclusive.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 Accepted opcodes are 0x70-0x7F (Jcc), 0xE0 (LOOPNE), 0xE1 (LOOPE), 0xE2 (LOOP) and 0xE3 (JCXZ).
REQ-019 The FSM states are IDLE, FETCH, EVAL and COMMIT; the FSM leaves IDLE only on start=1.
REQ-020 start while busy=1 is ignored; no state or output changes.
REQ-021 On start, the block latches opcode, flags, cx_in and ip_in; later changes on those inputs have no effect on the operation.
REQ-022 Unsupported opcode on start: -> COMMIT; done=1 next cycle with taken=0, no cx_wr, no ip_wr, and disp is not consumed.
REQ-023 Supported opcode on start: -> FETCH.
REQ-024 FETCH: disp_ready=1; stays in FETCH until disp_valid=1, then latches disp and -> EVAL.
REQ-025 disp_ready=0 in every state other than FETCH.
REQ-026 EVAL evaluates the condition using the latched values.
REQ-027 EVAL for LOOP/LOOPE/LOOPNE: cx_wr=1 and cx_out=cx-1 (mod 2^16) in this cycle only.
REQ-028 EVAL conditions, LOOP family: LOOP = (cx-1)!=0; LOOPE = (cx-1)!=0 & ZF; LOOPNE = (cx-1)!=0 & ~ZF.
REQ-029 EVAL conditions, JCXZ: cx==0, with no CX write.
REQ-030 EVAL conditions, Jcc: standard 8086 table keyed by opcode[3:0]: O, NO, B, NB, E, NE, BE, NBE, S, NS, P, NP, L(SF^OF), NL, LE((SF^OF)|ZF), NLE.
REQ-031 EVAL -> COMMIT; the decision is registered.
REQ-032 COMMIT: done=1; taken=decision; ip_wr=taken; ip_out = ip_in + sign_extend(disp), computed mod 2^16; -> IDLE.
REQ-033 Latency with disp_valid already high: start in cycle 0, disp accepted in cycle 1, cx_wr in cycle 2, done in cycle 3.
REQ-034 Each additional cycle of disp_valid=0 in FETCH adds exactly one cycle of latency.
REQ-035 ip_out and cx_out are 0 whenever their strobe is 0.
REQ-036 Wrap cases: LOOP with cx=0x0000 writes 0xFFFF and is taken; ip_in=0xFFFF with disp=0x02 gives ip_out=0x0001.
REQ-037 start can be accepted in the cycle immediately after done (back-to-back operation).

Reset
REQ-038 While reset=1: state=IDLE and every output is 0 (disp_ready, cx_wr, ip_wr, taken, busy, done, cx_out, ip_out), regardless of clk.
REQ-039 Reset asserted mid-operation aborts the operation: no further strobes, a pending disp is not consumed, and latched values are discarded.
REQ-040 After reset deasserts, the block waits for a new start.

Verification
REQ-041 JE (0x74), ZF=1, ip_in=0x0100, disp=0xFE valid -> cycle 3: done=1, taken=1, ip_wr=1, ip_out=0x00FE; no cx_wr.
REQ-042 JNLE (0x7F), SF=1, OF=0, ZF=0 -> done with taken=0 and ip_wr=0.
REQ-043 LOOP (0xE2), cx_in=0x0001 -> cx_wr with cx_out=0x0000 in cycle 2, then taken=0; a second run with cx_in=0x0000 -> cx_out=0xFFFF, taken=1.
REQ-044 LOOPNE (0xE0), cx_in=0x0005, ZF=1 -> cx_out=0x0004, taken=0; JCXZ (0xE3), cx_in=0x0000 -> taken=1 and no cx_wr.
REQ-045 Stall and abort: disp_valid=0 for 4 cycles -> done in cycle 7; start during busy is ignored; reset asserted in FETCH -> all outputs 0 immediately and disp never accepted.
REQ-046 Unsupported opcode 0x90 -> done in cycle 1 with taken=0 and disp_ready never asserted; a start in the next cycle is accepted.
